// File: rtl/core_boot_seq.sv
// Staged reset release for the dispatcher and two regular cores, each gated on its pc leaving the boot address.
// Optional: BOOT_AUTO_START_EN makes the first cycle after reset act as a boot_start.
module core_boot_seq #(
    parameter int STAGGER_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic        aclk,
    input  logic        arstn,
    input  logic        boot_start,
    input  logic        boot_abort,
    input  logic [31:0] dispatcher_rst_addr,
    input  logic [31:0] dispatcher_pc,
    input  logic [31:0] regular_0_rst_addr,
    input  logic [31:0] regular_0_pc,
    input  logic [31:0] regular_1_rst_addr,
    input  logic [31:0] regular_1_pc,
    output logic        dispatcher_rstn,
    output logic        regular_0_rstn,
    output logic        regular_1_rstn,
    output logic        boot_done,
    output logic        boot_err,
    output logic [2:0]  boot_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DISP = 3'd1;
    localparam logic [2:0] S_REG0 = 3'd2;
    localparam logic [2:0] S_REG1 = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [CNT_WIDTH-1:0] STG_LAST = CNT_WIDTH'(STAGGER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);

    logic [2:0]           state_q, state_d, stage_next;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 alive_q, alive_d;
    logic                 latch_en;
    logic [31:0]          disp_addr_q, reg0_addr_q, reg1_addr_q;
    logic [31:0]          stage_pc, stage_addr;
    logic                 mismatch, advance, timeout, start_req;
    logic                 disp_d, reg0_d, reg1_d, done_d, err_d;

`ifdef BOOT_AUTO_START_EN
    logic auto_q;

    // One-shot start request on the first cycle out of reset
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) auto_q <= 1'b1;
        else        auto_q <= 1'b0;
    end

    assign start_req = boot_start | auto_q;
`else
    assign start_req = boot_start;
`endif

    assign boot_state = state_q;

    // State, stage bookkeeping, latched addresses and registered outputs
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            alive_q         <= 1'b0;
            disp_addr_q     <= '0;
            reg0_addr_q     <= '0;
            reg1_addr_q     <= '0;
            dispatcher_rstn <= 1'b0;
            regular_0_rstn  <= 1'b0;
            regular_1_rstn  <= 1'b0;
            boot_done       <= 1'b0;
            boot_err        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            alive_q         <= alive_d;
            dispatcher_rstn <= disp_d;
            regular_0_rstn  <= reg0_d;
            regular_1_rstn  <= reg1_d;
            boot_done       <= done_d;
            boot_err        <= err_d;
            if (latch_en) begin
                disp_addr_q <= dispatcher_rst_addr;
                reg0_addr_q <= regular_0_rst_addr;
                reg1_addr_q <= regular_1_rst_addr;
            end
        end
    end

    // Select the core watched by the current stage and its successor state
    always_comb begin
        stage_pc   = '0;
        stage_addr = '0;
        stage_next = S_IDLE;
        case (state_q)
            S_DISP: begin
                stage_pc   = dispatcher_pc;
                stage_addr = disp_addr_q;
                stage_next = S_REG0;
            end
            S_REG0: begin
                stage_pc   = regular_0_pc;
                stage_addr = reg0_addr_q;
                stage_next = S_REG1;
            end
            S_REG1: begin
                stage_pc   = regular_1_pc;
                stage_addr = reg1_addr_q;
                stage_next = S_DONE;
            end
            default: ;
        endcase
    end

    assign mismatch = stage_pc != stage_addr;
    assign advance  = (alive_q | mismatch) & (cnt_q >= STG_LAST);
    assign timeout  = cnt_q >= TMO_LAST;

    // Next-state logic; abort overrides everything, advance beats timeout
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alive_d  = alive_q;
        latch_en = 1'b0;
        if (boot_abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            alive_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        state_d  = S_DISP;
                        cnt_d    = '0;
                        alive_d  = 1'b0;
                        latch_en = 1'b1;
                    end
                end
                S_DISP, S_REG0, S_REG1: begin
                    if (advance) begin
                        state_d = stage_next;
                        cnt_d   = '0;
                        alive_d = 1'b0;
                    end else if (timeout) begin
                        state_d = S_ERR;
                        cnt_d   = '0;
                        alive_d = 1'b0;
                    end else begin
                        cnt_d   = (cnt_q == TMO_MAX) ? cnt_q
                                : cnt_q + CNT_WIDTH'(1);
                        alive_d = alive_q | mismatch;
                    end
                end
                S_DONE, S_ERR: ;
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    alive_d = 1'b0;
                end
            endcase
        end
    end

    // Output values for the state being entered, registered on the same edge
    always_comb begin
        disp_d = 1'b0;
        reg0_d = 1'b0;
        reg1_d = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_d)
            S_DISP: disp_d = 1'b1;
            S_REG0: begin
                disp_d = 1'b1;
                reg0_d = 1'b1;
            end
            S_REG1: begin
                disp_d = 1'b1;
                reg0_d = 1'b1;
                reg1_d = 1'b1;
            end
            S_DONE: begin
                disp_d = 1'b1;
                reg0_d = 1'b1;
                reg1_d = 1'b1;
                done_d = 1'b1;
            end
            S_ERR:   err_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_core_boot_seq.sv
// Scoreboard bench for core_boot_seq.
// Expected state/outputs are queued per edge as stimulus is driven.
module tb_core_boot_seq;

    localparam logic [31:0] A_D = 32'h2000000;
    localparam logic [31:0] A_0 = 32'h2100000;
    localparam logic [31:0] A_1 = 32'h2200000;

    logic        aclk = 1'b0;
    logic        arstn = 1'b1;
    logic        boot_start = 1'b0;
    logic        boot_abort = 1'b0;
    logic [31:0] dispatcher_rst_addr = A_D;
    logic [31:0] regular_0_rst_addr = A_0;
    logic [31:0] regular_1_rst_addr = A_1;
    logic [31:0] dispatcher_pc, regular_0_pc, regular_1_pc;
    logic        dispatcher_rstn, regular_0_rstn, regular_1_rstn;
    logic        boot_done, boot_err;
    logic [2:0]  boot_state;

    int unsigned ecnt = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        int unsigned at;
        string       tag;
        logic [2:0]  st;
    } exp_t;
    exp_t q[$];

    int          run_d = 0, run_0 = 0, run_1 = 0;
    logic        hold_0 = 1'b0, hold_1 = 1'b0;
    logic [31:0] hval_0 = '0, hval_1 = '0;

    core_boot_seq #(
        .STAGGER_CYCLES(4),
        .TIMEOUT_CYCLES(32),
        .CNT_WIDTH(16)
    ) dut (
        .aclk(aclk),
        .arstn(arstn),
        .boot_start(boot_start),
        .boot_abort(boot_abort),
        .dispatcher_rst_addr(dispatcher_rst_addr),
        .dispatcher_pc(dispatcher_pc),
        .regular_0_rst_addr(regular_0_rst_addr),
        .regular_0_pc(regular_0_pc),
        .regular_1_rst_addr(regular_1_rst_addr),
        .regular_1_pc(regular_1_pc),
        .dispatcher_rstn(dispatcher_rstn),
        .regular_0_rstn(regular_0_rstn),
        .regular_1_rstn(regular_1_rstn),
        .boot_done(boot_done),
        .boot_err(boot_err),
        .boot_state(boot_state)
    );

    always #5 aclk = ~aclk;

    // Core model: pc leaves the boot address two cycles after release
    always @(posedge aclk) begin
        run_d <= !dispatcher_rstn ? 0 : (run_d < 2 ? run_d + 1 : run_d);
        run_0 <= !regular_0_rstn ? 0 : (run_0 < 2 ? run_0 + 1 : run_0);
        run_1 <= !regular_1_rstn ? 0 : (run_1 < 2 ? run_1 + 1 : run_1);
    end

    assign dispatcher_pc = (run_d >= 2) ? A_D + 32'd4 : A_D;
    assign regular_0_pc  = hold_0 ? hval_0
                         : ((run_0 >= 2) ? A_0 + 32'd4 : A_0);
    assign regular_1_pc  = hold_1 ? hval_1
                         : ((run_1 >= 2) ? A_1 + 32'd4 : A_1);

    function automatic logic [7:0] cur();
        return {boot_state, dispatcher_rstn, regular_0_rstn,
                regular_1_rstn, boot_done, boot_err};
    endfunction

    // Required {rstn x3, done, err} for each state code
    function automatic logic [7:0] exp_bits(input logic [2:0] st);
        logic [4:0] o;
        case (st)
            3'd1:    o = 5'b10000;
            3'd2:    o = 5'b11000;
            3'd3:    o = 5'b11100;
            3'd4:    o = 5'b11110;
            3'd5:    o = 5'b00001;
            default: o = 5'b00000;
        endcase
        return {st, o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input int unsigned at, input string tag,
                        input logic [2:0] st);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.st  = st;
        q.push_back(e);
    endtask

    // Compare queued expectations just after each edge
    always @(posedge aclk) begin
        exp_t e;
        ecnt++;
        #1;
        while (q.size() > 0 && q[0].at <= ecnt) begin
            e = q.pop_front();
            if (e.at < ecnt) chk({e.tag, "_missed"}, ecnt, e.at);
            else chk(e.tag, {24'd0, cur()}, {24'd0, exp_bits(e.st)});
        end
    end

    task automatic wait_edge(input int unsigned e);
        while (ecnt < e) @(negedge aclk);
    endtask

    task automatic start_hi(output int unsigned s);
        @(negedge aclk);
        boot_start = 1'b1;
        s = ecnt + 1;
    endtask

    task automatic start_lo();
        @(negedge aclk);
        boot_start = 1'b0;
    endtask

    task automatic abort_pulse(input string tag);
        @(negedge aclk);
        boot_abort = 1'b1;
        push(ecnt + 1, tag, 3'd0);
        @(negedge aclk);
        boot_abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s, t;
        #1 arstn = 1'b0;
        #2 chk("reset", {24'd0, cur()}, {24'd0, exp_bits(3'd0)});
        repeat (2) @(negedge aclk);
        arstn = 1'b1;
`ifdef BOOT_AUTO_START_EN
        push(ecnt + 1, "auto_start", 3'd1);
        wait_edge(ecnt + 1);
        abort_pulse("auto_abort");
`endif
        repeat (2) @(negedge aclk);

        // Normal boot
        start_hi(s);
        push(s, "n_disp", 3'd1);
        push(s + 3, "n_disp_min", 3'd1);
        push(s + 4, "n_reg0", 3'd2);
        push(s + 8, "n_reg1", 3'd3);
        push(s + 12, "n_done", 3'd4);
        start_lo();
        wait_edge(s + 13);

        // boot_start in DONE is ignored
        start_hi(t);
        push(t, "done_start", 3'd4);
        push(t + 1, "done_hold", 3'd4);
        start_lo();
        wait_edge(t + 1);
        abort_pulse("abort_done");
        repeat (2) @(negedge aclk);

        // Start and abort together in IDLE
        @(negedge aclk);
        boot_start = 1'b1;
        boot_abort = 1'b1;
        t = ecnt + 1;
        push(t, "both_idle", 3'd0);
        push(t + 1, "both_idle2", 3'd0);
        @(negedge aclk);
        boot_start = 1'b0;
        boot_abort = 1'b0;
        wait_edge(t + 2);

        // CSR change mid-boot uses the latched address
        hold_1 = 1'b1;
        hval_1 = 32'h3000000;
        start_hi(s);
        push(s, "c_disp", 3'd1);
        push(s + 8, "c_reg1", 3'd3);
        push(s + 12, "c_done", 3'd4);
        start_lo();
        regular_1_rst_addr = 32'h3000000;
        wait_edge(s + 12);
        abort_pulse("abort_c");
        regular_1_rst_addr = A_1;
        hold_1 = 1'b0;
        repeat (2) @(negedge aclk);

        // Timeout in REG0, then ERR ignores start
        hold_0 = 1'b1;
        hval_0 = A_0;
        start_hi(s);
        push(s + 4, "t_reg0", 3'd2);
        push(s + 35, "t_reg0_last", 3'd2);
        push(s + 36, "t_err", 3'd5);
        start_lo();
        wait_edge(s + 37);
        start_hi(t);
        push(t, "err_start", 3'd5);
        push(t + 1, "err_hold", 3'd5);
        start_lo();
        wait_edge(t + 1);
        abort_pulse("abort_err");
        hold_0 = 1'b0;
        repeat (2) @(negedge aclk);

        // Abort in REG1 and restart
        start_hi(s);
        push(s + 8, "a_reg1", 3'd3);
        start_lo();
        wait_edge(s + 9);
        abort_pulse("abort_reg1");
        start_hi(t);
        push(t, "restart", 3'd1);
        push(t + 4, "restart_reg0", 3'd2);
        start_lo();
        wait_edge(t + 5);

        // Async reset between edges in REG0
        #2 arstn = 1'b0;
        #1 chk("async_rst", {24'd0, cur()}, {24'd0, exp_bits(3'd0)});
        @(negedge aclk);
        arstn = 1'b1;
`ifdef BOOT_AUTO_START_EN
        push(ecnt + 1, "post_rst", 3'd1);
        wait_edge(ecnt + 1);
        abort_pulse("post_rst_abort");
`else
        push(ecnt + 1, "post_rst", 3'd0);
`endif
        repeat (3) @(negedge aclk);

        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_boot_seq.md
Name: core_boot_seq

Overview:
- Sequences the release of the dispatcher core and the two regular cores from reset, one core after another.
- The boot addresses come from the CSR block (dispatcher_rst_addr, regular_0_rst_addr, regular_1_rst_addr). Each core's pc is monitored to confirm it has left its boot address.
- Sits between the CSR block and the per-core reset inputs.
- Reports progress and failure through status outputs that the CSR block can expose as read-only registers.

Parameters:
- STAGGER_CYCLES, 16: minimum cycles a core stays in its stage after release before the next core is released; must be >= 1.
- TIMEOUT_CYCLES, 1024: cycles allowed per stage for the core's pc to leave its boot address; must be > STAGGER_CYCLES.
- CNT_WIDTH, 16: stage counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- aclk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- boot_start  in  1  single-cycle start request
- boot_abort  in  1  abort request; returns to IDLE from any state
- dispatcher_rst_addr  in  32  dispatcher boot address from CSR
- dispatcher_pc  in  32  dispatcher program counter
- regular_0_rst_addr  in  32  regular core 0 boot address
- regular_0_pc  in  32  regular core 0 program counter
- regular_1_rst_addr  in  32  regular core 1 boot address
- regular_1_pc  in  32  regular core 1 program counter
- dispatcher_rstn  out  1  dispatcher reset, active low
- regular_0_rstn  out  1  regular core 0 reset, active low
- regular_1_rstn  out  1  regular core 1 reset, active low
- boot_done  out  1  all cores released and alive
- boot_err  out  1  a stage timed out
- boot_state  out  3  current state encoding

Behaviour:
- Single clock aclk; reset is asynchronous, active-low on arstn.
- All outputs are registered.
- Reset values:
  - all three *_rstn = 0
  - boot_done = 0, boot_err = 0
  - boot_state = IDLE (3'd0)
  - counter = 0, latched addresses = 0
- States and encodings: IDLE=0, DISP=1, REG0=2, REG1=3, DONE=4, ERR=5. Codes 6 and 7 go to IDLE on the next edge with all outputs at reset values.
- IDLE:
  - all *_rstn = 0.
  - boot_start = 1 at an edge (with boot_abort = 0) moves to DISP.
  - The same edge latches all three rst_addr inputs, sets dispatcher_rstn = 1, clears the counter and clears the alive flag.
- Latched addresses are used for the whole sequence. CSR writes during a boot have no effect until the next boot_start.
- Per-stage operation (DISP, REG0, REG1):
  - The counter increments every cycle in the stage and saturates at TIMEOUT_CYCLES.
  - The alive flag sets in any cycle where the stage core's pc differs from its latched address. Once set it stays set until stage exit.
  - Advance condition: alive (or the pc mismatch in the current cycle) AND counter >= STAGGER_CYCLES-1.
- Transitions on advance:
  - DISP to REG0: regular_0_rstn = 1.
  - REG0 to REG1: regular_1_rstn = 1.
  - REG1 to DONE: boot_done = 1.
  - The counter and alive flag clear on every transition.
- Minimum stage duration is STAGGER_CYCLES cycles, so each release lags the previous one by at least STAGGER_CYCLES.
- Timeout: if counter == TIMEOUT_CYCLES-1 and the advance condition is false, go to ERR. On entry to ERR, all *_rstn = 0 and boot_err = 1.
- Advance beats timeout when both are true on the same cycle.
- DONE: all *_rstn stay 1 and boot_done stays 1. boot_start is ignored.
- ERR: all *_rstn stay 0 and boot_err stays 1. boot_start is ignored; only boot_abort or reset leaves ERR.
- boot_abort:
  - From any state, the next state is IDLE.
  - All *_rstn = 0, boot_done = 0, boot_err = 0.
  - boot_abort has priority over boot_start.
- boot_start outside IDLE is ignored.
- arstn low mid-sequence immediately forces all outputs to their reset values, asynchronously.

Optional Feature:
- Macro BOOT_AUTO_START_EN.
- Defined: the first cycle after arstn deasserts behaves as a boot_start in IDLE, so the sequence starts without software. This happens once per reset only; after boot_abort, an explicit boot_start is required.
- Undefined: the sequence starts only on boot_start.

Test Plan:
- Use STAGGER_CYCLES=4 and TIMEOUT_CYCLES=32 for all scenarios.
1. Normal boot:
   - Stimulus: dispatcher_rst_addr=32'h2000000, regular_0_rst_addr=32'h2100000, regular_1_rst_addr=32'h2200000; pulse boot_start; each pc moves to rst_addr+4 two cycles after its rstn rises.
   - Required: dispatcher_rstn rises at edge 0, regular_0_rstn at edge 4, regular_1_rstn at edge 8, boot_done at edge 12, boot_state sequence 1,2,3,4.
2. Timeout in REG0:
   - Stimulus: regular_0_pc held at 32'h2100000.
   - Required: ERR entered 32 cycles after REG0 entry; boot_err=1; all *_rstn=0; boot_state=5.
3. CSR change mid-boot:
   - Stimulus: regular_1_rst_addr changes to 32'h3000000 while in DISP; regular_1_pc held at 32'h3000000.
   - Required: REG1 still advances, because the latched address 32'h2200000 differs from the pc.
4. Abort:
   - Stimulus: boot_abort asserted during REG1, and separately in ERR.
   - Required: IDLE on the next edge; all *_rstn=0; boot_done=0 and boot_err=0. A new boot_start restarts from DISP.
5. Async reset mid-sequence:
   - Stimulus: arstn pulled low in REG0 between clock edges.
   - Required: outputs go to reset values immediately. With BOOT_AUTO_START_EN defined, dispatcher_rstn=1 one cycle after arstn releases.
6. Same-cycle requests:
   - Stimulus: boot_start and boot_abort both high in IDLE.
   - Required: stays in IDLE. Separately, boot_start in DONE leaves state and outputs unchanged.
